// File: rtl/prog_pkg.sv
// Shared types and constants for the program encoder and instr_pack.
package prog_pkg;

  typedef enum logic [1:0] {CLS_R, CLS_I, CLS_MEM, CLS_JMP} instr_class_t;

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR} state_t;

  // legal opcode window per instruction class (opcode 0 is reserved for halt)
  localparam logic [5:0] R_MIN   = 6'd1;
  localparam logic [5:0] R_MAX   = 6'd15;
  localparam logic [5:0] I_MIN   = 6'd16;
  localparam logic [5:0] I_MAX   = 6'd23;
  localparam logic [5:0] MEM_MIN = 6'd24;
  localparam logic [5:0] MEM_MAX = 6'd27;
  localparam logic [5:0] JMP_MIN = 6'd28;
  localparam logic [5:0] JMP_MAX = 6'd63;

  // field LSB positions in the 32-bit instruction word
  localparam int OPC_LSB = 26;
  localparam int RA_LSB  = 21;
  localparam int RB_LSB  = 16;
  localparam int RC_LSB  = 11;
  localparam int SH_LSB  = 6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_FULL    = 2'd2;

  typedef struct packed {
    logic         halt;
    instr_class_t cls;
    logic [5:0]   opcode;
    logic [4:0]   ra;
    logic [4:0]   rb;
    logic [4:0]   rc;
    logic [4:0]   shamt;
    logic [15:0]  imm;
  } instr_req_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit instruction word and flags
// whether the opcode is legal for the requested class. Halt always packs to 0.
module instr_pack
  import prog_pkg::*;
(
  input  instr_req_t  req,
  output logic [31:0] word,
  output logic        legal
);

  // pack fields by class and check the opcode window
  always_comb begin
    word  = '0;
    legal = 1'b0;
    if (req.halt) begin
      legal = 1'b1;
    end else begin
      word[OPC_LSB +: 6] = req.opcode;
      word[RA_LSB  +: 5] = req.ra;
      word[RB_LSB  +: 5] = req.rb;
      case (req.cls)
        CLS_R: begin
          word[RC_LSB +: 5] = req.rc;
          word[SH_LSB +: 5] = req.shamt;
          legal = (req.opcode >= R_MIN) && (req.opcode <= R_MAX);
        end
        CLS_I: begin
          word[15:0] = req.imm;
          legal = (req.opcode >= I_MIN) && (req.opcode <= I_MAX);
        end
        CLS_MEM: begin
          word[15:0] = req.imm;
          legal = (req.opcode >= MEM_MIN) && (req.opcode <= MEM_MAX);
        end
        default: begin
          // JMP_MAX is the top of the 6-bit range, so only the floor matters
          word[15:0] = req.imm;
          legal = (req.opcode >= JMP_MIN);
        end
      endcase
    end
  end

endmodule

// File: rtl/program_encoder.sv
// program_encoder: accepts field-level instruction requests, packs them and
// writes them sequentially into instruction memory until a halt word lands.
// Optional running XOR checksum of acknowledged words: PROG_ENCODER_CHECKSUM_EN.
module program_encoder
  import prog_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_ra,
  input  logic [4:0]        in_rb,
  input  logic [4:0]        in_rc,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic              in_halt,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_wr_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
`ifdef PROG_ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t      state, state_nxt;
  instr_req_t  req;
  logic [31:0] packed_word;
  logic        legal;
  logic        pend_halt;
  logic        full;
  logic        hs;
  logic        ack;

  assign req = '{halt: in_halt, cls: instr_class_t'(in_class), opcode: in_opcode,
                 ra: in_ra, rb: in_rb, rc: in_rc, shamt: in_shamt, imm: in_imm};

  instr_pack u_pack (.req(req), .word(packed_word), .legal(legal));

  assign full     = (count == FULL_CNT);
  assign in_ready = (state == S_ACCEPT);
  assign im_wr_en = (state == S_WRITE);
  assign busy     = (state == S_ACCEPT) || (state == S_WRITE);
  assign hs       = in_ready && in_valid;
  assign ack      = im_wr_en && im_wr_ack;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state; start wins over everything, including a pending write
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_ACCEPT;
    end else begin
      case (state)
        S_ACCEPT: if (in_valid) state_nxt = (!legal || full) ? S_ERROR : S_WRITE;
        S_WRITE:  if (im_wr_ack) state_nxt = pend_halt ? S_DONE : S_ACCEPT;
        default:  state_nxt = state;
      endcase
    end
  end

  // datapath: write word/address, counters, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_addr   <= BASE;
      im_wdata  <= '0;
      pend_halt <= 1'b0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (start) begin
      im_addr   <= BASE;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (hs) begin
      // illegal opcode takes precedence over the full check
      if (!legal) begin
        err      <= 1'b1;
        err_code <= ERR_ILLEGAL;
      end else if (full) begin
        err      <= 1'b1;
        err_code <= ERR_FULL;
      end else begin
        im_wdata  <= packed_word;
        pend_halt <= in_halt;
      end
    end else if (ack) begin
      im_addr <= im_addr + 1'b1;
      count   <= count + 1'b1;
      if (pend_halt) done <= 1'b1;
    end
  end

`ifdef PROG_ENCODER_CHECKSUM_EN
  // running XOR of every acknowledged word since start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     checksum <= '0;
    else if (start) checksum <= '0;
    else if (ack)   checksum <= checksum ^ im_wdata;
  end
`endif

endmodule

// File: tb/tb_program_encoder.sv
// Self-checking bench for program_encoder (ADDR_W=2 so memory-full is reachable).
module tb_program_encoder;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, in_valid, in_halt, im_wr_ack;
  logic          in_ready, im_wr_en, busy, done, err;
  logic [1:0]    in_class, err_code;
  logic [5:0]    in_opcode;
  logic [4:0]    in_ra, in_rb, in_rc, in_shamt;
  logic [15:0]   in_imm;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   count;
`ifdef PROG_ENCODER_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          m_active, m_done, m_err;
  int          m_code, m_addr, m_count;
  logic [31:0] m_csum;

  program_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb),
    .in_rc(in_rc), .in_shamt(in_shamt), .in_imm(in_imm), .in_halt(in_halt),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_wdata(im_wdata), .im_wr_ack(im_wr_ack),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
`ifdef PROG_ENCODER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_f(input int cls, input int op, input bit halt);
    if (halt) return 1;
    case (cls)
      0:       return op >= 1  && op <= 15;
      1:       return op >= 16 && op <= 23;
      2:       return op >= 24 && op <= 27;
      default: return op >= 28 && op <= 63;
    endcase
  endfunction

  function automatic logic [31:0] pack_f(input int cls, input int op, input int ra, input int rb,
                                         input int rc, input int sh, input int imm, input bit halt);
    longint w;
    if (halt) return 32'h0;
    w = op * 2**26 + ra * 2**21 + rb * 2**16;
    if (cls == 0) w += rc * 2**11 + sh * 2**6;
    else          w += imm;
    return w[31:0];
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_cnt"},  count,    m_count);
    check({tag, "_addr"}, im_addr,  m_addr);
    check({tag, "_done"}, done,     m_done);
    check({tag, "_err"},  err,      m_err);
    check({tag, "_code"}, err_code, m_code);
    check({tag, "_rdy"},  in_ready, m_active);
`ifdef PROG_ENCODER_CHECKSUM_EN
    check({tag, "_csum"}, checksum, m_csum);
`endif
  endtask

  // called just after a negedge; leaves just after a negedge
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_active = 1; m_done = 0; m_err = 0; m_code = 0; m_addr = 0; m_count = 0; m_csum = '0;
    check_status("start");
  endtask

  task automatic send(input int cls, input int op, input int ra, input int rb, input int rc,
                      input int sh, input int imm, input bit halt, input int delay);
    logic [31:0] w;
    bit          lg;
    w  = pack_f(cls, op, ra, rb, rc, sh, imm, halt);
    lg = legal_f(cls, op, halt);
    check("pre_rdy", in_ready, m_active);
    in_valid = 1'b1; in_class = 2'(cls); in_opcode = 6'(op); in_ra = 5'(ra); in_rb = 5'(rb);
    in_rc = 5'(rc); in_shamt = 5'(sh); in_imm = 16'(imm); in_halt = halt;
    im_wr_ack = 1'($urandom_range(0, 1));   // stray ack outside WRITE must be ignored
    @(negedge clk);
    in_valid = 1'b0; im_wr_ack = 1'b0;
    if (!m_active) begin
      check("noacc_wen", im_wr_en, 0);
    end else if (!lg) begin
      m_active = 0; m_err = 1; m_code = 1;
      check("ill_wen", im_wr_en, 0);
    end else if (m_count == 2**AW) begin
      m_active = 0; m_err = 1; m_code = 2;
      check("full_wen", im_wr_en, 0);
    end else begin
      for (int d = 0; d <= delay; d++) begin
        check("wr_wen",   im_wr_en, 1);
        check("wr_wdata", im_wdata, w);
        check("wr_addr",  im_addr,  m_addr);
        check("wr_busy",  busy,     1);
        im_wr_ack = (d == delay);
        @(negedge clk);
      end
      im_wr_ack = 1'b0;
      m_addr = (m_addr + 1) % (2**AW);
      m_count++;
      m_csum ^= w;
      if (halt) begin m_done = 1; m_active = 0; end
      check("post_wen", im_wr_en, 0);
    end
    check_status("post");
    check("busy", busy, m_active);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_halt = 1'b0; im_wr_ack = 1'b0;
    in_class = '0; in_opcode = '0; in_ra = '0; in_rb = '0; in_rc = '0; in_shamt = '0; in_imm = '0;
    m_active = 0; m_done = 0; m_err = 0; m_code = 0; m_addr = 0; m_count = 0; m_csum = '0;
    repeat (2) @(negedge clk);
    check_status("reset");
    check("reset_wen",   im_wr_en, 0);
    check("reset_busy",  busy,     0);
    check("reset_wdata", im_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 5, 3, 1, 2, 4, 0, 0, 0);   // no start yet: ignored in IDLE

    // directed program: R, I, halt
    do_start();
    send(0, 5, 3, 1, 2, 4, 0, 0, 0);
    check("plan_w0", m_csum, 32'h14611100);
    send(1, 18, 7, 2, 0, 0, 16'hBEEF, 0, 1);
    send(2, 25, 1, 1, 1, 1, 1, 1, 0);  // halt overrides other fields
    check("plan_done", done, 1);
    check("plan_cnt3", count, 3);
`ifdef PROG_ENCODER_CHECKSUM_EN
    check("plan_csum", checksum, 32'h5C83AFEF);
`endif
    send(0, 5, 0, 0, 0, 0, 0, 0, 0);   // DONE ignores requests

    // illegal opcode for class
    do_start();
    send(1, 5, 1, 2, 3, 0, 16'h1234, 0, 0);
    check("ill_code", err_code, 1);
    do_start();
    check("ill_clr", err, 0);

    // fill memory with wrap, then overflow
    for (int i = 0; i < 4; i++) send(3, 28 + i, i, i, 0, 0, 16'hA000 + i, 0, i % 2);
    check("wrap_addr", im_addr, 0);
    send(2, 24, 1, 1, 0, 0, 5, 1, 0);  // halt also hits the full check
    check("full_code", err_code, 2);

    // delayed ack, then start mid-WRITE with a colliding ack
    do_start();
    send(2, 26, 4, 5, 0, 0, 16'h00FF, 0, 3);
    in_valid = 1'b1; in_class = 2'd1; in_opcode = 6'd20; in_halt = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("ab_wen1", im_wr_en, 1);
    start = 1'b1; im_wr_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; im_wr_ack = 1'b0;
    m_active = 1; m_done = 0; m_err = 0; m_code = 0; m_addr = 0; m_count = 0; m_csum = '0;
    check("ab_wen0", im_wr_en, 0);
    check_status("abort");

    // randomized loads
    for (int l = 0; l < 40; l++) begin
      int n;
      do_start();
      n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        int cls, op, lo, hi;
        cls = $urandom_range(0, 3);
        case (cls)
          0: begin lo = 1;  hi = 15; end
          1: begin lo = 16; hi = 23; end
          2: begin lo = 24; hi = 27; end
          default: begin lo = 28; hi = 63; end
        endcase
        op = ($urandom_range(0, 9) < 8) ? $urandom_range(lo, hi) : $urandom_range(0, 63);
        send(cls, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 65535), ($urandom_range(0, 9) == 0),
             $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
